icache_refill: RTL and testbench

- Miss-refill controller directly downstream of the instruction cache.
- Consumes the cache's miss indication and 28-bit block address, and fetches the 4-word (128-bit) line from memory over a word-wide request/acknowledge bus.
- Writes the assembled line, tag and valid bit into the tag/data arrays, then signals completion so the cache drops miss_stall and re-reads as a hit.

---
 rtl/icache_refill_pkg.sv | 20 ++
 rtl/icache_line_buffer.sv | 28 ++
 rtl/icache_refill.sv | 119 +++++++++++
 tb/tb_icache_refill.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/icache_refill_pkg.sv
// Shared types and constants for the instruction-cache miss-refill controller.
package icache_refill_pkg;

    localparam int ICACHE_INDEX_W = 8;
    localparam int ICACHE_TAG_W   = 20;
    localparam int ICACHE_WORD_W  = 32;
    localparam int ICACHE_WORDS   = 4;
    localparam int ICACHE_LINE_W  = ICACHE_WORD_W * ICACHE_WORDS;

    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        FILL = 2'd2,
        DONE = 2'd3
    } refill_state_e;

endpackage

// File: rtl/icache_line_buffer.sv
// Word-indexed line assembly register; word n lands in bits [32n+31:32n].
module icache_line_buffer
    import icache_refill_pkg::*;
#(
    parameter int WORDS  = ICACHE_WORDS,
    parameter int WORD_W = ICACHE_WORD_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       we,
    input  logic [$clog2(WORDS)-1:0]   idx,
    input  logic [WORD_W-1:0]          wdata,
    output logic [WORDS*WORD_W-1:0]    line
);

    logic [WORDS-1:0][WORD_W-1:0] words_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            words_q <= '0;
        end else if (we) begin
            words_q[idx] <= wdata;
        end
    end

    assign line = words_q;

endmodule

// File: rtl/icache_refill.sv
// Instruction-cache miss refill: fetches a 4-word line over a req/ack bus
// and writes it, with tag and valid, into the cache arrays.
//
// state | meaning
// IDLE  | waiting for a miss; counter cleared
// REQ   | requesting word cnt_q, holding bus_addr until ack
// FILL  | one-cycle array write of the assembled line
// DONE  | one-cycle completion pulse
module icache_refill
    import icache_refill_pkg::*;
#(
    parameter int WORDS_PER_LINE = ICACHE_WORDS,
    parameter int INDEX_W        = ICACHE_INDEX_W,
    parameter int TAG_W          = ICACHE_TAG_W
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic                                            miss_req,
    input  logic [TAG_W+INDEX_W-1:0]                        miss_addr,
    input  logic                                            flush,
    output logic                                            bus_req,
    output logic [TAG_W+INDEX_W+$clog2(WORDS_PER_LINE)-1:0] bus_addr,
    input  logic                                            bus_ack,
    input  logic [ICACHE_WORD_W-1:0]                        bus_rd_data,
    output logic                                            fill_we,
    output logic [INDEX_W-1:0]                              fill_index,
    output logic [TAG_W-1:0]                                fill_tag,
    output logic [ICACHE_WORD_W*WORDS_PER_LINE-1:0]         fill_data,
    output logic                                            fill_valid,
    output logic                                            refill_busy,
    output logic                                            refill_done
);

    localparam int ADDR_W = TAG_W + INDEX_W;
    localparam int CNT_W  = $clog2(WORDS_PER_LINE);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORDS_PER_LINE - 1);

    refill_state_e     state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic              bus_req_q;
    logic              fill_we_q;
    logic              done_q;
    logic              word_we;

    // flush wins over a coincident ack, so the word is not captured either
    assign word_we = (state_q == REQ) && bus_ack && !flush;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            bus_req_q <= DISABLE;
            fill_we_q <= DISABLE;
            done_q    <= DISABLE;
        end else begin
            fill_we_q <= DISABLE;
            done_q    <= DISABLE;
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (miss_req && !flush) begin
                        addr_q    <= miss_addr;
                        bus_req_q <= ENABLE;
                        state_q   <= REQ;
                    end
                end
                REQ: begin
                    if (flush) begin
                        cnt_q     <= '0;
                        bus_req_q <= DISABLE;
                        state_q   <= IDLE;
                    end else if (bus_ack) begin
                        if (cnt_q == CNT_LAST) begin
                            cnt_q     <= '0;
                            bus_req_q <= DISABLE;
                            fill_we_q <= ENABLE;
                            state_q   <= FILL;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                FILL: begin
                    done_q  <= ENABLE;
                    state_q <= DONE;
                end
                DONE: begin
                    cnt_q   <= '0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    icache_line_buffer #(
        .WORDS  (WORDS_PER_LINE),
        .WORD_W (ICACHE_WORD_W)
    ) u_line_buffer (
        .clk   (clk),
        .rst   (rst),
        .we    (word_we),
        .idx   (cnt_q),
        .wdata (bus_rd_data),
        .line  (fill_data)
    );

    assign bus_req     = bus_req_q;
    assign bus_addr    = {addr_q, cnt_q};
    assign fill_we     = fill_we_q;
    assign fill_valid  = fill_we_q;
    assign fill_index  = addr_q[INDEX_W-1:0];
    assign fill_tag    = addr_q[ADDR_W-1:INDEX_W];
    assign refill_busy = (state_q != IDLE);
    assign refill_done = done_q;

endmodule

// File: tb/tb_icache_refill.sv
// Directed bench for icache_refill with a scoreboard of expected bus addresses and fills.
module tb_icache_refill;

    logic         clk = 1'b0;
    logic         rst;
    logic         miss_req;
    logic [27:0]  miss_addr;
    logic         flush;
    logic         bus_req;
    logic [29:0]  bus_addr;
    logic         bus_ack;
    logic [31:0]  bus_rd_data;
    logic         fill_we;
    logic [7:0]   fill_index;
    logic [19:0]  fill_tag;
    logic [127:0] fill_data;
    logic         fill_valid;
    logic         refill_busy;
    logic         refill_done;

    always #5 clk = ~clk;

    icache_refill dut (
        .clk         (clk),
        .rst         (rst),
        .miss_req    (miss_req),
        .miss_addr   (miss_addr),
        .flush       (flush),
        .bus_req     (bus_req),
        .bus_addr    (bus_addr),
        .bus_ack     (bus_ack),
        .bus_rd_data (bus_rd_data),
        .fill_we     (fill_we),
        .fill_index  (fill_index),
        .fill_tag    (fill_tag),
        .fill_data   (fill_data),
        .fill_valid  (fill_valid),
        .refill_busy (refill_busy),
        .refill_done (refill_done)
    );

    typedef struct packed {
        logic [7:0]   index;
        logic [19:0]  tag;
        logic [127:0] data;
    } fill_t;

    logic [29:0] exp_bus[$];
    fill_t       exp_fill[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_bus_req"},     128'(bus_req),     128'd0);
        check({tag, "_bus_addr"},    128'(bus_addr),    128'd0);
        check({tag, "_fill_we"},     128'(fill_we),     128'd0);
        check({tag, "_fill_index"},  128'(fill_index),  128'd0);
        check({tag, "_fill_tag"},    128'(fill_tag),    128'd0);
        check({tag, "_fill_data"},   fill_data,         128'd0);
        check({tag, "_fill_valid"},  128'(fill_valid),  128'd0);
        check({tag, "_busy"},        128'(refill_busy), 128'd0);
        check({tag, "_done"},        128'(refill_done), 128'd0);
    endtask

    // abort_kind: 0 none, 1 flush with 2nd ack, 2 reset after 3rd word, 3 flush during FILL
    task automatic run_refill(input logic [27:0] addr, input logic [31:0] base, input logic [31:0] step,
                              input int wait_cyc, input bit change_addr, input bit hold_miss,
                              input int abort_kind, output int busy_cyc);
        int           acks = 0;
        int           waitc = 0;
        int           cyc = 0;
        int           fill_cyc = -10;
        bit           finished = 1'b0;
        logic [127:0] line;
        logic [29:0]  w;
        fill_t        f;
        for (int k = 0; k < 4; k++) begin
            exp_bus.push_back({addr, 2'(k)});
            line[32*k +: 32] = base + step * 32'(k);
        end
        if (abort_kind == 0 || abort_kind == 3)
            exp_fill.push_back('{addr[7:0], addr[27:8], line});
        miss_req  = 1'b1;
        miss_addr = addr;
        busy_cyc  = 0;
        while (!finished && cyc < 300) begin
            @(negedge clk);
            cyc++;
            bus_ack = 1'b0;
            flush   = 1'b0;
            if (!hold_miss) miss_req = 1'b0;
            if (change_addr) miss_addr = ~addr;
            if (refill_busy) busy_cyc++;
            if (abort_kind == 2 && acks == 3) begin
                rst = 1'b0;
                finished = 1'b1;
            end else if (bus_req) begin
                if (exp_bus.size() == 0) begin
                    check("bus_req_extra", 128'(bus_req), 128'd0);
                end else if (waitc < wait_cyc) begin
                    check("bus_addr_hold", 128'(bus_addr), 128'(exp_bus[0]));
                    waitc++;
                end else begin
                    w = exp_bus.pop_front();
                    check("bus_addr", 128'(bus_addr), 128'(w));
                    acks++;
                    waitc = 0;
                    bus_ack = 1'b1;
                    bus_rd_data = base + step * 32'(w[1:0]);
                    if (abort_kind == 1 && acks == 2) begin
                        flush = 1'b1;
                        finished = 1'b1;
                    end
                end
            end
            if (fill_we) begin
                if (exp_fill.size() == 0) begin
                    check("fill_we_extra", 128'(fill_we), 128'd0);
                end else begin
                    f = exp_fill.pop_front();
                    check("fill_index", 128'(fill_index), 128'(f.index));
                    check("fill_tag",   128'(fill_tag),   128'(f.tag));
                    check("fill_data",  fill_data,        f.data);
                    check("fill_valid", 128'(fill_valid), 128'd1);
                end
                fill_cyc = cyc;
                if (abort_kind == 3) flush = 1'b1;
            end
            if (refill_done) begin
                check("done_after_fill", 128'(cyc), 128'(fill_cyc + 1));
                finished = 1'b1;
            end
        end
        check("refill_finished", 128'(finished), 128'd1);
    endtask

    initial begin
        int busy;
        bit seen_bad;
        rst = 1'b0; miss_req = 1'b0; miss_addr = '0; flush = 1'b0;
        bus_ack = 1'b0; bus_rd_data = '0;

        // reset state
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b1;
        @(negedge clk);

        // zero-wait refill
        run_refill(28'hABCDE12, 32'h11111111, 32'h11111111, 0, 1'b0, 1'b0, 0, busy);
        check("busy_zero_wait", 128'(busy), 128'd6);
        @(negedge clk);
        check("idle_after_refill", 128'(refill_busy), 128'd0);

        // wait states, 3 cycles per word
        run_refill(28'h1234567, 32'hDEAD0000, 32'h00010001, 3, 1'b0, 1'b0, 0, busy);
        check("busy_wait3", 128'(busy), 128'd18);
        @(negedge clk);

        // flush blocks acceptance in IDLE
        miss_req = 1'b1; miss_addr = 28'h5555555; flush = 1'b1;
        @(negedge clk);
        check("flush_idle_blocks", 128'(refill_busy), 128'd0);
        miss_req = 1'b0; flush = 1'b0;

        // flush coincident with 2nd ack
        run_refill(28'h0F0F0F0, 32'hA5A50000, 32'h00000003, 1, 1'b0, 1'b0, 1, busy);
        @(negedge clk);
        flush = 1'b0; bus_ack = 1'b0;
        check("flush_to_idle_busy", 128'(refill_busy), 128'd0);
        check("flush_to_idle_req",  128'(bus_req),     128'd0);
        exp_bus.delete();
        seen_bad = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (fill_we || refill_done) seen_bad = 1'b1;
        end
        check("flush_no_fill_done", 128'(seen_bad), 128'd0);
        run_refill(28'h0F0F0F1, 32'h01020304, 32'h10101010, 0, 1'b0, 1'b0, 0, busy);
        check("busy_after_flush", 128'(busy), 128'd6);
        @(negedge clk);

        // reset after the 3rd word
        run_refill(28'h7654321, 32'hCAFE0000, 32'h00000101, 0, 1'b0, 1'b0, 2, busy);
        @(negedge clk);
        rst = 1'b1;
        check_all_zero("mid_reset");
        exp_bus.delete();
        run_refill(28'h7654322, 32'h0BADF00D, 32'h11110000, 2, 1'b0, 1'b0, 0, busy);
        check("busy_after_reset", 128'(busy), 128'd14);
        @(negedge clk);

        // miss_addr changes after acceptance
        run_refill(28'h89ABC3D, $urandom, 32'h01234567, 1, 1'b1, 1'b0, 0, busy);
        @(negedge clk);

        // flush during FILL still completes the write and done pulse
        run_refill(28'h2468ACE, 32'h13579BDF, 32'h22222222, 0, 1'b0, 1'b0, 3, busy);
        check("busy_flush_fill", 128'(busy), 128'd6);
        @(negedge clk);

        // back-to-back misses with miss_req held across DONE
        run_refill(28'hFEDCBA9, 32'h00000001, 32'h00000002, 0, 1'b0, 1'b1, 0, busy);
        @(negedge clk);
        check("b2b_idle_gap", 128'({refill_busy, bus_req}), 128'd0);
        run_refill(28'hFEDCBA8, 32'h80000000, 32'h00000010, 0, 1'b0, 1'b1, 0, busy);
        miss_req = 1'b0;
        check("b2b_second_busy", 128'(busy), 128'd6);
        @(negedge clk);
        check("final_idle", 128'(refill_busy), 128'd0);
        check("scoreboard_empty", 128'(exp_fill.size() + exp_bus.size()), 128'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
